wb_cmd_master: RTL

//  Parametrised Wishbone classic single-access master driven by a valid/ready command port.

---
 rtl/wb_cmd_master.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-access master fed by a valid/ready command port.
// Every accepted command turns into exactly one Wishbone cycle (read or write,
// byte-selectable). The result comes back on a valid/ready response port
// carrying the read data and an error flag. Typical placement: between a
// command FIFO and the Wishbone interconnect.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer keeps valid and payload steady
// until that edge, and ready never depends on valid in the same cycle.
//
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to abort a bus cycle that
// is not terminated within TIMEOUT_CYC cycles. Without the macro the master
// waits for ack/err for as long as it takes, and rsp_tmo is tied low.
//
// Parameters
//   ADDR_W       address width
//   DATA_W       data width, multiple of 8
//   SEL_W        byte-select width, always DATA_W/8
//   TIMEOUT_CYC  wait-cycle limit for ack/err (1..65535, timeout build only)
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_we/adr/dat/sel  command payload (1 = write)
//   rsp_valid/ready     response handshake
//   rsp_dat             read data (0 for writes and for any error)
//   rsp_err             slave error or timeout
//   rsp_tmo             timeout abort
//   wb_*_o              Wishbone master outputs, all registered
//   wb_dat_i/ack_i/err_i Wishbone slave inputs
//   dbg_state           current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module wb_cmd_master #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255,
   localparam int unsigned SEL_W      = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_adr,
   input  logic [DATA_W-1:0] cmd_dat,
   input  logic [SEL_W-1:0]  cmd_sel,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_dat,
   output logic              rsp_err,
   output logic              rsp_tmo,

   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic [SEL_W-1:0]  wb_sel_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,

   output logic [1:0]        dbg_state
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ---------------------------------------------------------------------------
   if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
      $error("wb_cmd_master: DATA_W must be a non-zero multiple of 8");
   end

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("wb_cmd_master: TIMEOUT_CYC must be in 1..65535");
   end

   // ---------------------------------------------------------------------------
   // FSM state
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   // Single-cycle strobes from the next-state logic into the datapath.
   logic load_cmd;   // command accepted this cycle
   logic finish;     // slave terminated the bus cycle (ack and/or err)
   logic timeout;    // bus cycle aborted by the wait counter
   logic rsp_done;   // response handed off this cycle

   logic bus_term;   // slave termination seen on the bus
   logic expired;    // wait counter has reached its limit this cycle

   assign bus_term = wb_ack_i | wb_err_i;

   // ---------------------------------------------------------------------------
   // Optional wait counter
   // ---------------------------------------------------------------------------
`ifdef WB_CMD_MASTER_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic        rsp_tmo_q;

   // The counter sits at zero outside BUS, so it is cleared on every entry.
   // It counts BUS cycles that end without ack/err; the cycle in which the
   // count would reach TIMEOUT_CYC is the expiry cycle, so cyc/stb stay high
   // for exactly TIMEOUT_CYC unterminated cycles. A termination in the expiry
   // cycle is taken as normal completion (bus_term is checked first below).
   assign expired = (wait_cnt == 16'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state_q != BUS) begin
         wait_cnt <= '0;
      end else if (!bus_term) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_tmo_q <= 1'b0;
      end else if (finish || timeout) begin
         rsp_tmo_q <= timeout;
      end else if (rsp_done) begin
         rsp_tmo_q <= 1'b0;
      end
   end

   assign rsp_tmo = rsp_tmo_q;
`else
   assign expired = 1'b0;
   assign rsp_tmo = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and datapath strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      load_cmd = 1'b0;
      finish   = 1'b0;
      timeout  = 1'b0;
      rsp_done = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               load_cmd = 1'b1;
               state_d  = BUS;
            end
         end
         BUS: begin
            if (bus_term) begin
               finish  = 1'b1;
               state_d = RESP;
            end else if (expired) begin
               timeout = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_q == IDLE);
   assign dbg_state = state_q;

   // ---------------------------------------------------------------------------
   // Wishbone outputs
   // ---------------------------------------------------------------------------
   // Address, data and select keep their last value after the cycle ends; only
   // cyc/stb/we are meaningful to the slave once cyc is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
      end else if (load_cmd) begin
         wb_cyc_o <= 1'b1;
         wb_stb_o <= 1'b1;
         wb_we_o  <= cmd_we;
         wb_adr_o <= cmd_adr;
         wb_dat_o <= cmd_dat;
         wb_sel_o <= cmd_sel;
      end else if (finish || timeout) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Response outputs
   // ---------------------------------------------------------------------------
   // Read data is only returned on a clean read ack; ack together with err is
   // an error, and writes and timeouts return zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_dat   <= '0;
      end else if (finish || timeout) begin
         rsp_valid <= 1'b1;
         rsp_err   <= wb_err_i | timeout;
         rsp_dat   <= (finish && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
      end else if (rsp_done) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_dat   <= '0;
      end
   end

endmodule
